ignition_scheduler: RTL and testbench

Sequences several igniter channels through the launcher's single capacitor/PWM fire path. Per-channel fire requests are arbitrated round-robin, one channel at a time, each time:

1. request a capacitor charge,
2. close the channel relay and let it settle,
3. enable the fire path until the blaster reports completion or a burn window expires,
4. open the relay.

It sits between the pad/remote request logic and the blaster fire input and relay drivers. It keeps sticky per-channel done/failed status for the display and telemetry.

---
 rtl/ignition_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_ignition_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ignition_scheduler.sv
// ignition_scheduler: round-robin sequencer for several igniter channels that
// share one capacitor charger and one blaster fire path. Each grant walks
// charge -> relay settle -> fire window -> relay release. Per-channel sticky
// done/failed flags are kept for display and telemetry.
module ignition_scheduler #(
  parameter int          NCH         = 4,
  parameter logic [15:0] GAP_CYCLES  = 16'd480,
  parameter logic [15:0] BURN_CYCLES = 16'd48000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NCH-1:0]         req,
  input  logic                   arm,
  input  logic                   charge_ok,
  input  logic                   fire_done,
  input  logic                   fault,
  input  logic                   clear,
  output logic                   charge_req,
  output logic [NCH-1:0]         sel,
  output logic                   fire,
  output logic [$clog2(NCH)-1:0] grant_id,
  output logic [NCH-1:0]         done,
  output logic [NCH-1:0]         failed,
  output logic                   busy,
  output logic                   faulted
);

  localparam int IDW = $clog2(NCH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHARGE  = 3'd1,
    ST_SELECT  = 3'd2,
    ST_FIRE    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   ptr_reg, ptr_next;
  logic [IDW-1:0]   grant_id_reg, grant_id_next;
  logic [15:0]      cnt_reg, cnt_next;
  logic             charge_req_reg, charge_req_next;
  logic [NCH-1:0]   sel_reg, sel_next;
  logic             fire_reg, fire_next;
  logic [NCH-1:0]   done_reg, done_next;
  logic [NCH-1:0]   failed_reg, failed_next;
  logic             busy_reg, busy_next;
  logic             faulted_reg, faulted_next;

  // Channels still waiting for service: requested and not yet finished.
  logic [NCH-1:0]   pending;
  logic [IDW-1:0]   cand_idx [NCH];
  logic [NCH-1:0]   cand_hit;
  logic [NCH-1:0]   sel_onehot;
  logic             found;
  logic [IDW-1:0]   pick;

  assign pending = req & ~done_reg & ~failed_reg;

  // Candidate gi is the channel gi steps after the pointer (cyclic), and the
  // one-hot relay pattern for the currently granted channel.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_cand
      logic [IDW:0] sum;
      assign sum           = {1'b0, ptr_reg} + (IDW+1)'(gi);
      assign cand_idx[gi]  = (sum >= (IDW+1)'(NCH)) ? IDW'(sum - (IDW+1)'(NCH))
                                                    : sum[IDW-1:0];
      assign cand_hit[gi]  = pending[cand_idx[gi]];
      assign sel_onehot[gi] = (grant_id_reg == IDW'(gi));
    end
  endgenerate

  // Pick the pending candidate closest to the pointer (lowest offset wins).
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        found = 1'b1;
        pick  = cand_idx[i];
      end
    end
  end

  // Next-state and registered-output logic for the service sequence.
  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    grant_id_next   = grant_id_reg;
    cnt_next        = cnt_reg;
    charge_req_next = charge_req_reg;
    sel_next        = sel_reg;
    fire_next       = fire_reg;
    done_next       = done_reg;
    failed_next     = failed_reg;

    case (state_reg)
      ST_IDLE: begin
        if (clear) begin
          done_next   = '0;
          failed_next = '0;
        end else if (arm && found) begin
          grant_id_next   = pick;
          charge_req_next = 1'b1;
          state_next      = ST_CHARGE;
        end
      end

      ST_CHARGE: begin
        if (!arm) begin
          charge_req_next = 1'b0;
          fire_next       = 1'b0;
          cnt_next        = GAP_CYCLES - 16'd1;
          state_next      = ST_RELEASE;
        end else if (charge_ok) begin
          sel_next   = sel_onehot;
          cnt_next   = GAP_CYCLES - 16'd1;
          state_next = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (!arm) begin
          charge_req_next = 1'b0;
          fire_next       = 1'b0;
          cnt_next        = GAP_CYCLES - 16'd1;
          state_next      = ST_RELEASE;
        end else if (cnt_reg == 16'd0) begin
          charge_req_next = 1'b0;
          fire_next       = 1'b1;
          cnt_next        = BURN_CYCLES - 16'd1;
          state_next      = ST_FIRE;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end

      ST_FIRE: begin
        if (fault) begin
          // Over-current: drop everything at once, no relay dwell.
          charge_req_next = 1'b0;
          sel_next        = '0;
          fire_next       = 1'b0;
          state_next      = ST_FAULT;
        end else if (!arm || fire_done || cnt_reg == 16'd0) begin
          if (arm && fire_done) begin
            done_next = done_reg | sel_onehot;
          end else if (arm) begin
            failed_next = failed_reg | sel_onehot;
          end
          charge_req_next = 1'b0;
          fire_next       = 1'b0;
          cnt_next        = GAP_CYCLES - 16'd1;
          state_next      = ST_RELEASE;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end

      ST_RELEASE: begin
        if (cnt_reg == 16'd0) begin
          sel_next   = '0;
          ptr_next   = (grant_id_reg == IDW'(NCH - 1)) ? '0 : grant_id_reg + 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end

      ST_FAULT: begin
        if (clear && !arm) begin
          done_next   = '0;
          failed_next = '0;
          state_next  = ST_IDLE;
        end
      end

      default: begin
        charge_req_next = 1'b0;
        sel_next        = '0;
        fire_next       = 1'b0;
        state_next      = ST_IDLE;
      end
    endcase
  end

  assign busy_next    = (state_next != ST_IDLE);
  assign faulted_next = (state_next == ST_FAULT);

  // State and output registers; reset drops every drive line immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      ptr_reg        <= '0;
      grant_id_reg   <= '0;
      cnt_reg        <= '0;
      charge_req_reg <= 1'b0;
      sel_reg        <= '0;
      fire_reg       <= 1'b0;
      done_reg       <= '0;
      failed_reg     <= '0;
      busy_reg       <= 1'b0;
      faulted_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      grant_id_reg   <= grant_id_next;
      cnt_reg        <= cnt_next;
      charge_req_reg <= charge_req_next;
      sel_reg        <= sel_next;
      fire_reg       <= fire_next;
      done_reg       <= done_next;
      failed_reg     <= failed_next;
      busy_reg       <= busy_next;
      faulted_reg    <= faulted_next;
    end
  end

  assign charge_req = charge_req_reg;
  assign sel        = sel_reg;
  assign fire       = fire_reg;
  assign grant_id   = grant_id_reg;
  assign done       = done_reg;
  assign failed     = failed_reg;
  assign busy       = busy_reg;
  assign faulted    = faulted_reg;

endmodule

// File: tb/tb_ignition_scheduler.sv
// tb_ignition_scheduler: directed scenarios for ignition_scheduler with
// NCH=4, GAP_CYCLES=4, BURN_CYCLES=20. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_ignition_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic       arm, charge_ok, fire_done, fault, clear;
  logic       charge_req, fire, busy, faulted;
  logic [3:0] sel, done, failed;
  logic [1:0] grant_id;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int n, w;
  logic fs;

  ignition_scheduler #(
    .NCH(4),
    .GAP_CYCLES(16'd4),
    .BURN_CYCLES(16'd20)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .arm(arm),
    .charge_ok(charge_ok),
    .fire_done(fire_done),
    .fault(fault),
    .clear(clear),
    .charge_req(charge_req),
    .sel(sel),
    .fire(fire),
    .grant_id(grant_id),
    .done(done),
    .failed(failed),
    .busy(busy),
    .faulted(faulted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req       = 4'b0000;
    arm       = 1'b0;
    charge_ok = 1'b0;
    fire_done = 1'b0;
    fault     = 1'b0;
    clear     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_charge(output int cyc);
    cyc = 0;
    while (charge_req !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_sel(output int cyc);
    cyc = 0;
    while (sel === 4'b0000 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_fire(output int cyc);
    cyc = 0;
    while (fire !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Holds fire_done/fault for one cycle at FIRE cycle kd/kf; returns fire width.
  task automatic fire_phase(input int kd, input int kf, output int width);
    width = 0;
    while (fire === 1'b1 && width < 100) begin
      fire_done = (width == kd);
      fault     = (width == kf);
      @(negedge clk);
      width++;
    end
    fire_done = 1'b0;
    fault     = 1'b0;
  endtask

  task automatic sel_low(output int cyc, output logic fire_seen);
    cyc       = 0;
    fire_seen = 1'b0;
    while (sel !== 4'b0000 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (fire === 1'b1) fire_seen = 1'b1;
    end
  endtask

  initial begin
    int order [3];
    logic [3:0] acc;
    order = '{0, 1, 3};

    // Reset state
    do_reset();
    reset_n = 1'b0;
    check("rst_charge_req", charge_req, 0);
    check("rst_sel", sel, 0);
    check("rst_fire", fire, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_done", done, 0);
    check("rst_failed", failed, 0);
    check("rst_busy", busy, 0);
    check("rst_faulted", faulted, 0);
    $display("reset: outputs sampled");
    @(negedge clk);
    reset_n = 1'b1;

    // 1. Single channel, normal completion
    arm = 1'b1;
    req = 4'b0100;
    wait_charge(n);
    check("s1_grant_latency", n, 1);
    check("s1_grant_id", grant_id, 2);
    check("s1_busy", busy, 1);
    @(negedge clk);
    check("s1_sel_before_charge_ok", sel, 0);
    charge_ok = 1'b1;
    wait_sel(n);
    charge_ok = 1'b0;
    check("s1_sel_latency", n, 1);
    check("s1_sel", sel, 4'b0100);
    wait_fire(n);
    check("s1_fire_delay", n, 4);
    fire_phase(7, -1, w);
    check("s1_fire_width", w, 8);
    check("s1_done", done, 4'b0100);
    check("s1_failed", failed, 0);
    sel_low(n, fs);
    check("s1_sel_release", n, 4);
    check("s1_busy_low", busy, 0);
    $display("s1: ch=2 fire_width=%0d release=%0d done=%b", w, n, done);

    // 2. Round-robin ordering
    do_reset();
    arm       = 1'b1;
    charge_ok = 1'b1;
    req       = 4'b1011;
    acc       = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      acc = acc | (4'b0001 << order[i]);
      wait_charge(n);
      check("s2_grant_latency", n, 1);
      check("s2_grant_id", grant_id, order[i]);
      wait_sel(n);
      check("s2_sel", sel, 4'b0001 << order[i]);
      wait_fire(n);
      check("s2_fire_delay", n, 4);
      fire_phase(2, -1, w);
      check("s2_fire_width", w, 3);
      check("s2_done", done, acc);
      sel_low(n, fs);
      check("s2_sel_release", n, 4);
      check("s2_busy_low", busy, 0);
      $display("s2: ch=%0d fire_width=%0d done=%b", grant_id, w, done);
    end
    repeat (10) @(negedge clk);
    check("s2_idle_busy", busy, 0);
    check("s2_idle_charge_req", charge_req, 0);
    check("s2_idle_done", done, 4'b1011);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("s2_clear_done", done, 0);
    check("s2_clear_no_grant", busy, 0);
    wait_charge(n);
    check("s2_regrant_latency", n, 1);
    check("s2_regrant_ptr_wrap", grant_id, 0);
    $display("s2: after clear grant_id=%0d", grant_id);

    // 3. Burn window timeout
    do_reset();
    arm       = 1'b1;
    charge_ok = 1'b1;
    req       = 4'b0001;
    wait_charge(n);
    check("s3_grant_id", grant_id, 0);
    wait_sel(n);
    wait_fire(n);
    check("s3_fire_delay", n, 4);
    fire_phase(-1, -1, w);
    check("s3_fire_width", w, 20);
    check("s3_failed", failed, 4'b0001);
    check("s3_done", done, 0);
    sel_low(n, fs);
    check("s3_sel_release", n, 4);
    repeat (10) @(negedge clk);
    check("s3_no_regrant_busy", busy, 0);
    check("s3_no_regrant_charge", charge_req, 0);
    $display("s3: ch=0 fire_width=%0d failed=%b", w, failed);

    // 4. Over-current fault (channel 0 already failed, so channel 1 is served)
    req = 4'b0011;
    wait_charge(n);
    check("s4_grant_latency", n, 1);
    check("s4_grant_id", grant_id, 1);
    wait_sel(n);
    check("s4_sel", sel, 4'b0010);
    wait_fire(n);
    fire_phase(-1, 5, w);
    check("s4_fire_width", w, 6);
    check("s4_fire", fire, 0);
    check("s4_sel_off", sel, 0);
    check("s4_charge_req", charge_req, 0);
    check("s4_faulted", faulted, 1);
    check("s4_busy", busy, 1);
    check("s4_done", done, 0);
    clear = 1'b1;
    @(negedge clk);
    check("s4_clear_armed_ignored", faulted, 1);
    check("s4_failed_kept", failed, 4'b0001);
    arm = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    check("s4_exit_faulted", faulted, 0);
    check("s4_exit_busy", busy, 0);
    check("s4_exit_failed", failed, 0);
    check("s4_exit_done", done, 0);
    $display("s4: fault after width=%0d, cleared", w);

    // 5. Disarm during SELECT
    do_reset();
    arm       = 1'b1;
    charge_ok = 1'b1;
    req       = 4'b0100;
    wait_charge(n);
    wait_sel(n);
    check("s5_sel", sel, 4'b0100);
    arm = 1'b0;
    sel_low(n, fs);
    check("s5_sel_hold", n, 5);
    check("s5_fire_never", fs, 0);
    check("s5_done", done, 0);
    check("s5_failed", failed, 0);
    repeat (10) @(negedge clk);
    check("s5_no_grant_busy", busy, 0);
    check("s5_no_grant_charge", charge_req, 0);
    $display("s5: disarm, sel released after %0d cycles", n);

    // 6. Asynchronous reset mid-FIRE
    do_reset();
    arm       = 1'b1;
    charge_ok = 1'b1;
    req       = 4'b0101;
    wait_charge(n);
    wait_sel(n);
    wait_fire(n);
    fire_phase(0, -1, w);
    check("s6_first_width", w, 1);
    check("s6_first_done", done, 4'b0001);
    sel_low(n, fs);
    wait_charge(n);
    check("s6_second_grant", grant_id, 2);
    wait_sel(n);
    wait_fire(n);
    check("s6_in_fire", fire, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("s6_async_fire", fire, 0);
    check("s6_async_sel", sel, 0);
    check("s6_async_charge", charge_req, 0);
    check("s6_async_busy", busy, 0);
    check("s6_async_done", done, 0);
    check("s6_async_grant", grant_id, 0);
    req = 4'b1111;
    @(negedge clk);
    reset_n = 1'b1;
    wait_charge(n);
    check("s6_post_reset_latency", n, 1);
    check("s6_post_reset_ptr", grant_id, 0);
    $display("s6: async reset, next grant_id=%0d", grant_id);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
